fft_frame_streamer: RTL and testbench
=====================================

FFT_FRAME_STREAMER -- requirements
Module: fft_frame_streamer

Interface
REQ-001 Parameter N_SAMPLES, default 512, meaning samples per frame (power of two, 4..1024).
REQ-002 Parameter SAMPLE_W, default 8, meaning bits per input sample (2..16).
REQ-003 Parameter CORE_W, default 32, meaning FFT core word width (at least 2*SAMPLE_W).
REQ-004 Parameter REAL_LSB, default 16, meaning bit position of the sample LSB inside the real half of the core word.
REQ-005 The interface SHALL consist of exactly the following ports: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 frame_in  input  N_SAMPLES*SAMPLE_W  frame from SPI; sample 0 occupies the MSBs.
REQ-009 frame_valid  input  1  level; frame_in holds a complete frame.
REQ-010 frame_ack  output  1  combinational; frame_valid AND a free buffer exists, so frame_in is captured on this edge.
REQ-011 core_busy  input  1  FFT core cannot accept a sample this cycle.
REQ-012 sample_out  output  CORE_W  extended sample word to the FFT core.
REQ-013 sample_load  output  1  sample_out is valid and is consumed this cycle.
REQ-014 frame_start  output  1  one-cycle pulse; the last sample of a frame was loaded.
REQ-015 idx  output  clog2(N_SAMPLES)  index of the sample currently presented.
REQ-016 buf_count  output  2  number of full buffers, 0..2.

Function
REQ-017 Two frame buffers SHALL operate ping-pong: one write buffer and one read buffer, each toggling independently after use.
REQ-018 On a frame_ack edge, frame_in SHALL be latched into the write buffer, buf_count SHALL increment, and the write pointer SHALL toggle.
REQ-019 With buf_count==2, frame_ack SHALL be 0 and the upstream SHALL hold frame_valid; no frame is dropped.
REQ-020 States: IDLE, STREAM, START.
REQ-021 IDLE->STREAM when buf_count>0, with idx=0.
REQ-022 In STREAM: sample_load = NOT core_busy; idx SHALL advance only on a load; while core_busy=1, idx and sample_out SHALL hold.
REQ-023 STREAM->START on the load with idx==N_SAMPLES-1.
REQ-024 In START: frame_start=1 and sample_load=0; the read buffer SHALL be freed and the read pointer toggled.
REQ-025 START SHALL go to STREAM with idx=0 if the other buffer is full, else to IDLE.
REQ-026 In START, a capture and a free on the same edge SHALL leave buf_count unchanged.
REQ-027 Latency: the first sample_load SHALL occur in the cycle after the capture edge when starting from IDLE with core_busy=0.
REQ-028 Back-to-back frames: gap between the last load of frame k and the first load of frame k+1 SHALL be exactly one cycle (START).
REQ-029 sample_out SHALL be 0 everywhere except bits REAL_LSB+SAMPLE_W-1..REAL_LSB, which carry the sample; the imaginary half SHALL be 0.
REQ-030 In IDLE and START, sample_out SHALL be 0.

Reset
REQ-031 reset low SHALL immediately force: state IDLE, idx 0, buf_count 0, both pointers 0, sample_load 0, frame_start 0, sample_out 0; buffer contents are don't-care.
REQ-032 Reset mid-STREAM SHALL abandon both frames; frame_start SHALL NOT pulse for them.
REQ-033 While reset is low, frame_ack SHALL be 0.

Configuration
REQ-034 Macro FFT_STREAMER_SIGNED_EN: when defined, the sample SHALL be treated as two's complement and sign-extended through bit CORE_W-1 of the real half; when undefined, the bits above the sample SHALL be zero, as in REQ-029.

Verification
REQ-035 Defaults; frame_in sample k = k[7:0]; frame_valid=1 for one cycle; core_busy=0 -> frame_ack=1 at t0; loads at t0+1..t0+512; sample_out = {8'h00, k, 16'h0000}; frame_start at t0+513; buf_count returns to 0.
REQ-036 Three frames presented continuously -> ack for frames 1 and 2 at once; frame 3 ack only on the START edge of frame 1; exactly one idle cycle between frames; all 1536 samples are in order.
REQ-037 core_busy high for idx 5..9 (5 cycles) -> sample_load=0 for those cycles, and idx and sample_out are held at sample 5; frame_start is delayed by exactly 5 cycles.
REQ-038 reset low at idx=200 with buf_count=2 -> all outputs zero the same cycle; no frame_start; the next frame is streamed from idx 0.
REQ-039 N_SAMPLES=4, SAMPLE_W=8, FFT_STREAMER_SIGNED_EN defined, sample 8'h80 -> sample_out = 32'hFF800000; without the macro -> 32'h00800000.

Source files
------------

// File: rtl/fft_frame_streamer.sv
// fft_frame_streamer: double-buffered frame capture feeding an FFT core one
// extended sample per cycle.
//
// Handshakes:
//   frame_valid/frame_ack : frame_valid is a level held by the upstream until
//     frame_ack is seen high; frame_in is captured on the rising edge that
//     ends a frame_ack=1 cycle.
//   sample_load : acts as valid AND ready combined. A sample is transferred
//     on every cycle with sample_load=1. core_busy=1 blocks the transfer, and
//     sample_out and idx hold until the core accepts.
//
// Configuration macro: FFT_STREAMER_SIGNED_EN. When it is defined, samples
// are sign-extended through the top of the real half. When it is undefined,
// the bits above the sample are zero-filled.
//
// The FSM state is kept in the internal signal 'state' so that checkers can
// bind to it.
module fft_frame_streamer #(
  parameter int N_SAMPLES = 512,
  parameter int SAMPLE_W  = 8,
  parameter int CORE_W    = 32,
  parameter int REAL_LSB  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_SAMPLES*SAMPLE_W-1:0]  frame_in,
  input  logic                           frame_valid,
  output logic                           frame_ack,
  input  logic                           core_busy,
  output logic [CORE_W-1:0]              sample_out,
  output logic                           sample_load,
  output logic                           frame_start,
  output logic [$clog2(N_SAMPLES)-1:0]   idx,
  output logic [1:0]                     buf_count
);

  localparam int IDX_W = $clog2(N_SAMPLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_START  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]    idx_next;
  logic [1:0]          buf_count_next;
  logic                wr_ptr, rd_ptr;
  logic                free_slot;
  logic                release_buf;
  logic [SAMPLE_W-1:0] cur_sample;

  // Ping-pong frame storage. It has no reset because stale contents are never read.
  logic [SAMPLE_W-1:0] buf_mem [2][N_SAMPLES];

  // A buffer is free if one is empty, or if the read buffer is being released on this edge.
  always_comb begin
    release_buf = (state == ST_START);
    free_slot   = (buf_count != 2'd2) || release_buf;
    frame_ack   = frame_valid && reset && free_slot;
    buf_count_next = 2'(buf_count + {1'b0, frame_ack} - {1'b0, release_buf});
  end

  // Capture the whole frame into the write buffer. Sample 0 sits in the MSBs of frame_in.
  always_ff @(posedge clk) begin
    if (frame_ack) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        buf_mem[wr_ptr][k] <= frame_in[(N_SAMPLES-1-k)*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  // State, index, occupancy and buffer pointers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      buf_count <= 2'd0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      buf_count <= buf_count_next;
      if (frame_ack)   wr_ptr <= ~wr_ptr;
      if (release_buf) rd_ptr <= ~rd_ptr;
    end
  end

  // Next-state logic and index advance. A capture counts as "full" so that
  // streaming can start on the capture edge itself.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    case (state)
      ST_IDLE: begin
        idx_next = '0;
        if ((buf_count != 2'd0) || frame_ack) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        if (!core_busy) begin
          if (idx == LAST_IDX) begin
            state_next = ST_START;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      ST_START: begin
        idx_next   = '0;
        state_next = (buf_count_next != 2'd0) ? ST_STREAM : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // Output strobes and the extended sample word. The word is zero outside STREAM.
  always_comb begin
    sample_load = (state == ST_STREAM) && !core_busy;
    frame_start = (state == ST_START);
    cur_sample  = buf_mem[rd_ptr][idx];
    sample_out  = '0;
    if (state == ST_STREAM) begin
      sample_out[REAL_LSB +: SAMPLE_W] = cur_sample;
`ifdef FFT_STREAMER_SIGNED_EN
      for (int b = REAL_LSB + SAMPLE_W; b < CORE_W; b++) begin
        sample_out[b] = cur_sample[SAMPLE_W-1];
      end
`else
      // Bits above the sample stay zero.
`endif
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// tb_fft_frame_streamer: directed bench with a queue-based model of the
// sample stream, plus a small N_SAMPLES=4 instance for the extension check.
module tb_fft_frame_streamer;

  localparam int N = 512;

  // Clock/reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // Main DUT (defaults)
  logic [N*8-1:0] frame_in = '0;
  logic           frame_valid = 1'b0;
  logic           frame_ack;
  logic           core_busy = 1'b0;
  logic [31:0]    sample_out;
  logic           sample_load;
  logic           frame_start;
  logic [8:0]     idx;
  logic [1:0]     buf_count;

  fft_frame_streamer u_dut (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ack(frame_ack), .core_busy(core_busy), .sample_out(sample_out),
    .sample_load(sample_load), .frame_start(frame_start), .idx(idx),
    .buf_count(buf_count)
  );

  // Small DUT (N_SAMPLES=4)
  logic [31:0] s_frame = '0;
  logic        s_valid = 1'b0;
  logic        s_ack;
  logic        s_busy = 1'b0;
  logic [31:0] s_out;
  logic        s_load;
  logic        s_start;
  logic [1:0]  s_idx;
  logic [1:0]  s_count;

  fft_frame_streamer #(.N_SAMPLES(4)) u_small (
    .clk(clk), .reset(reset), .frame_in(s_frame), .frame_valid(s_valid),
    .frame_ack(s_ack), .core_busy(s_busy), .sample_out(s_out),
    .sample_load(s_load), .frame_start(s_start), .idx(s_idx),
    .buf_count(s_count)
  );

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  int fl_q[$];   // cycles of each idx-0 load
  int st_q[$];   // cycles of each frame_start pulse
  int load_cnt = 0;
  bit prev_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ext_word(input logic [7:0] s);
`ifdef FFT_STREAMER_SIGNED_EN
    return {{8{s[7]}}, s, 16'h0000};
`else
    return {8'h00, s, 16'h0000};
`endif
  endfunction

  function automatic logic [N*8-1:0] make_frame(input int off);
    logic [N*8-1:0] f;
    for (int k = 0; k < N; k++) f[(N-1-k)*8 +: 8] = 8'(k + off);
    return f;
  endfunction

  task automatic push_frame(input int off);
    for (int k = 0; k < N; k++) exp_q.push_back(ext_word(8'(k + off)));
  endtask

  // Compare process: every cycle, check the DUT outputs against the model.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      load_cnt = 0;
      prev_last = 1'b0;
    end else begin
      check("frame_start", {31'b0, frame_start}, {31'b0, prev_last});
      if (frame_start) st_q.push_back(cyc);
      if (sample_load) begin
        if (exp_q.size() == 0) begin
          check("unexpected_load", 32'd1, 32'd0);
        end else begin
          check("sample_out", sample_out, exp_q[0]);
          check("idx", {23'b0, idx}, 32'(load_cnt % N));
          void'(exp_q.pop_front());
        end
        if (load_cnt % N == 0) fl_q.push_back(cyc);
        prev_last = (load_cnt % N == N - 1);
        load_cnt++;
      end else begin
        prev_last = 1'b0;
        if (core_busy && (load_cnt % N != 0) && exp_q.size() > 0)
          check("held_sample_out", sample_out, exp_q[0]);
        else
          check("idle_sample_out", sample_out, 32'h0);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_ack) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_starts(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (st_q.size() >= n) break;
      @(negedge clk);
    end
    if (st_q.size() < n) check("start_timeout", 32'(st_q.size()), 32'(n));
  endtask

  task automatic wait_idx(input logic [8:0] target, input int budget);
    bit hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (idx == target && sample_load) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("idx_timeout", 32'(idx), 32'(target));
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, a0, a1, a2;
    logic [31:0] small_exp[4];

    // Reset state, including ack gating while reset is low
    #2;
    reset = 1'b0;
    frame_valid = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    check("rst_frame_ack", {31'b0, frame_ack}, 32'd0);
    check("rst_sample_load", {31'b0, sample_load}, 32'd0);
    check("rst_frame_start", {31'b0, frame_start}, 32'd0);
    check("rst_sample_out", sample_out, 32'h0);
    check("rst_idx", {23'b0, idx}, 32'd0);
    check("rst_buf_count", {30'b0, buf_count}, 32'd0);
    check("rst_small_ack", {31'b0, s_ack}, 32'd0);
    step();
    frame_valid = 1'b0;
    s_valid = 1'b0;
    reset = 1'b1;
    step();

    // Single ramp frame: ack at t0, loads t0+1..t0+512, frame_start at t0+513
    fl_q.delete(); st_q.delete();
    frame_in = make_frame(0);
    frame_valid = 1'b1;
    @(negedge clk);
    check("t1_ack", {31'b0, frame_ack}, 32'd1);
    t0 = cyc;
    push_frame(0);
    step();
    frame_valid = 1'b0;
    @(negedge clk);
    check("t1_first_word", sample_out, 32'h00000000);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check("t1_word3", sample_out, 32'h00030000);
    wait_starts(1, 700);
    check("t1_first_load_cyc", 32'(fl_q[0]), 32'(t0 + 1));
    check("t1_start_cyc", 32'(st_q[0]), 32'(t0 + 513));
    @(negedge clk);
    check("t1_buf_count_end", {30'b0, buf_count}, 32'd0);

    // Three frames with frame_valid held: acks at a0, a0+1, a0+513
    step();
    fl_q.delete(); st_q.delete();
    frame_in = make_frame(0 * 85);
    frame_valid = 1'b1;
    wait_ack(10, a0);
    push_frame(0 * 85);
    step();
    frame_in = make_frame(1 * 85);
    wait_ack(10, a1);
    push_frame(1 * 85);
    check("t2_ack1_cyc", 32'(a1), 32'(a0 + 1));
    step();
    frame_in = make_frame(2 * 85);
    @(negedge clk);
    check("t2_buf_full", {30'b0, buf_count}, 32'd2);
    check("t2_ack_blocked", {31'b0, frame_ack}, 32'd0);
    wait_ack(700, a2);
    push_frame(2 * 85);
    check("t2_ack2_cyc", 32'(a2), 32'(a0 + 513));
    step();
    frame_valid = 1'b0;
    wait_starts(3, 1700);
    check("t2_fl0", 32'(fl_q[0]), 32'(a0 + 1));
    check("t2_st0", 32'(st_q[0]), 32'(a0 + 513));
    check("t2_fl1", 32'(fl_q[1]), 32'(a0 + 514));
    check("t2_st1", 32'(st_q[1]), 32'(a0 + 1026));
    check("t2_fl2", 32'(fl_q[2]), 32'(a0 + 1027));
    check("t2_st2", 32'(st_q[2]), 32'(a0 + 1539));
    check("t2_all_consumed", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t2_buf_count_end", {30'b0, buf_count}, 32'd0);

    // core_busy while idx is 5: five held cycles, frame_start five cycles late
    step();
    st_q.delete(); fl_q.delete();
    frame_in = make_frame(0);
    frame_valid = 1'b1;
    wait_ack(10, t0);
    push_frame(0);
    step();
    frame_valid = 1'b0;
    wait_idx(9'd5, 50);
    core_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t3_busy_no_load", {31'b0, sample_load}, 32'd0);
      check("t3_busy_idx", {23'b0, idx}, 32'd5);
      check("t3_busy_word", sample_out, 32'h00050000);
      step();
    end
    core_busy = 1'b0;
    wait_starts(1, 700);
    check("t3_start_cyc", 32'(st_q[0]), 32'(t0 + 518));

    // Reset at idx 200 with two frames buffered
    step();
    frame_in = make_frame(11);
    frame_valid = 1'b1;
    wait_ack(10, a0);
    push_frame(11);
    step();
    frame_in = make_frame(99);
    wait_ack(10, a1);
    push_frame(99);
    step();
    frame_valid = 1'b0;
    wait_idx(9'd200, 300);
    check("t4_buf_full", {30'b0, buf_count}, 32'd2);
    reset = 1'b0;
    frame_valid = 1'b1;
    @(negedge clk);
    check("t4_rst_load", {31'b0, sample_load}, 32'd0);
    check("t4_rst_start", {31'b0, frame_start}, 32'd0);
    check("t4_rst_word", sample_out, 32'h0);
    check("t4_rst_idx", {23'b0, idx}, 32'd0);
    check("t4_rst_count", {30'b0, buf_count}, 32'd0);
    check("t4_rst_ack", {31'b0, frame_ack}, 32'd0);
    step();
    reset = 1'b1;
    frame_valid = 1'b0;
    st_q.delete(); fl_q.delete();
    repeat (20) @(negedge clk);
    check("t4_no_start", 32'(st_q.size()), 32'd0);
    step();
    frame_in = make_frame(200);
    frame_valid = 1'b1;
    wait_ack(10, t0);
    push_frame(200);
    step();
    frame_valid = 1'b0;
    wait_starts(1, 700);
    check("t4_fl", 32'(fl_q[0]), 32'(t0 + 1));
    check("t4_st", 32'(st_q[0]), 32'(t0 + 513));

    // N_SAMPLES=4 instance: extension of 80, 7F, 01, FF
`ifdef FFT_STREAMER_SIGNED_EN
    small_exp = '{32'hFF800000, 32'h007F0000, 32'h00010000, 32'hFFFF0000};
`else
    small_exp = '{32'h00800000, 32'h007F0000, 32'h00010000, 32'h00FF0000};
`endif
    step();
    s_frame = 32'h807F01FF;
    s_valid = 1'b1;
    @(negedge clk);
    check("t5_ack", {31'b0, s_ack}, 32'd1);
    step();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_load", {31'b0, s_load}, 32'd1);
      check("t5_idx", {30'b0, s_idx}, 32'(i));
      check("t5_word", s_out, small_exp[i]);
    end
    @(negedge clk);
    check("t5_start", {31'b0, s_start}, 32'd1);
    check("t5_start_word", s_out, 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
